// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: pattern mode encoding,
// counter widths and named timing sets for common video modes.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_BLACK = 2'd3
    } vga_mode_e;

    localparam int PIX_X_W = 11;
    localparam int PIX_Y_W = 10;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t TIMING_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    localparam vga_timing_t TIMING_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-source bus: the generator requests a coordinate, the source
// answers with colour a fixed number of clocks later.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 4
);
    import vga_pkg::*;

    logic               pix_req;
    logic [PIX_X_W-1:0] pix_x;
    logic [PIX_Y_W-1:0] pix_y;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    modport master (
        output pix_req, pix_x, pix_y,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  pix_req, pix_x, pix_y,
        output pix_r, pix_g, pix_b
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear to zero; depth 0 is a
// plain wire so callers can instantiate it unconditionally.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_shift
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
                logic [WIDTH-1:0] stage_reg;
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) stage_reg <= '0;
                        else        stage_reg <= d;
                    end
                end else begin : g_next
                    always_ff @(posedge clk or negedge rst_n) begin
                        if (!rst_n) stage_reg <= '0;
                        else        stage_reg <= g_stage[gi-1].stage_reg;
                    end
                end
            end
            assign q = g_stage[DEPTH-1].stage_reg;
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with built-in test patterns or an external pixel source;
// every output is delayed PIX_LAT+1 clocks so it lines up with source data.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = TIMING_800X600_60.h_active,
    parameter int H_FP      = TIMING_800X600_60.h_fp,
    parameter int H_SYNC    = TIMING_800X600_60.h_sync,
    parameter int H_BP      = TIMING_800X600_60.h_bp,
    parameter int V_ACTIVE  = TIMING_800X600_60.v_active,
    parameter int V_FP      = TIMING_800X600_60.v_fp,
    parameter int V_SYNC    = TIMING_800X600_60.v_sync,
    parameter int V_BP      = TIMING_800X600_60.v_bp,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    parameter int COLOR_W   = 4,
    parameter int PIX_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    vga_timing_gen_if.master    pix,
    output logic                hsync,
    output logic                vsync,
    output logic [COLOR_W-1:0]  red_out,
    output logic [COLOR_W-1:0]  green_out,
    output logic [COLOR_W-1:0]  blue_out,
    output logic                frame_start,
    output logic                line_end
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int SAMPLE_W = 6 + 3 * COLOR_W;

    logic [PIX_X_W-1:0] x_reg;
    logic [PIX_Y_W-1:0] y_reg;
    logic [2:0]         bar_reg;
    logic [PIX_X_W-1:0] bar_pix_reg;
    vga_mode_e          mode_reg;

    logic last_x, last_y, at_origin, visible, h_raw, v_raw, ext_sel;
    logic [COLOR_W-1:0] int_r, int_g, int_b;
    vga_mode_e          eff_mode;

    assign last_x    = (x_reg == PIX_X_W'(H_TOTAL - 1));
    assign last_y    = (y_reg == PIX_Y_W'(V_TOTAL - 1));
    assign at_origin = (x_reg == '0) && (y_reg == '0);
    assign visible   = (x_reg < PIX_X_W'(H_ACTIVE)) && (y_reg < PIX_Y_W'(V_ACTIVE));
    assign h_raw     = (x_reg >= PIX_X_W'(H_ACTIVE + H_FP)) &&
                       (x_reg <= PIX_X_W'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign v_raw     = (y_reg >= PIX_Y_W'(V_ACTIVE + V_FP)) &&
                       (y_reg <= PIX_Y_W'(V_ACTIVE + V_FP + V_SYNC - 1));

    assign pix.pix_req = en && visible;
    assign pix.pix_x   = x_reg;
    assign pix.pix_y   = y_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (!en) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (last_x) begin
            x_reg <= '0;
            y_reg <= last_y ? '0 : y_reg + 1'b1;
        end else begin
            x_reg <= x_reg + 1'b1;
        end
    end

    // Bar index advances every BAR_W visible pixels, avoiding a divide by H_ACTIVE/8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_reg     <= '0;
            bar_pix_reg <= '0;
        end else if (!en || last_x) begin
            bar_reg     <= '0;
            bar_pix_reg <= '0;
        end else if (x_reg < PIX_X_W'(H_ACTIVE)) begin
            if (bar_pix_reg == PIX_X_W'(BAR_W - 1)) begin
                bar_pix_reg <= '0;
                bar_reg     <= bar_reg + 1'b1;
            end else begin
                bar_pix_reg <= bar_pix_reg + 1'b1;
            end
        end
    end

    // The origin pixel already uses the newly sampled mode, so a frame is never split.
    assign eff_mode = at_origin ? vga_mode_e'(mode) : mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                mode_reg <= MODE_BLACK;
        else if (en && at_origin)  mode_reg <= vga_mode_e'(mode);
    end

    always_comb begin
        int_r   = '0;
        int_g   = '0;
        int_b   = '0;
        ext_sel = 1'b0;
        case (eff_mode)
            MODE_EXT:  ext_sel = 1'b1;
            MODE_GRAD: begin
                int_r = COLOR_W'(y_reg >> 2);
                int_g = COLOR_W'(x_reg >> 2);
                int_b = COLOR_W'(x_reg >> 4);
            end
            MODE_BARS: begin
                int_r = {COLOR_W{~bar_reg[1]}};
                int_g = {COLOR_W{~bar_reg[2]}};
                int_b = {COLOR_W{~bar_reg[0]}};
            end
            default: ;
        endcase
    end

    logic [SAMPLE_W-1:0] sample, delayed;
    logic d_h, d_v, d_fs, d_le, d_vis, d_ext;
    logic [COLOR_W-1:0] d_r, d_g, d_b;

    assign sample = en ? {h_raw, v_raw, at_origin, last_x, visible, ext_sel, int_r, int_g, int_b}
                       : '0;

    vga_delay_line #(
        .WIDTH (SAMPLE_W),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sample),
        .q     (delayed)
    );

    assign {d_h, d_v, d_fs, d_le, d_vis, d_ext, d_r, d_g, d_b} = delayed;

    // External colour arrives exactly when the delayed sample emerges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            red_out     <= '0;
            green_out   <= '0;
            blue_out    <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            hsync       <= d_h ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= d_v ? VSYNC_POL : ~VSYNC_POL;
            frame_start <= d_fs;
            line_end    <= d_le;
            if (!d_vis) begin
                red_out   <= '0;
                green_out <= '0;
                blue_out  <= '0;
            end else if (d_ext) begin
                red_out   <= pix.pix_r;
                green_out <= pix.pix_g;
                blue_out  <= pix.pix_b;
            end else begin
                red_out   <= d_r;
                green_out <= d_g;
                blue_out  <= d_b;
            end
        end
    end

endmodule
